// File: rtl/dircc_debug_pkg.sv
// Shared definitions for the Nios II debug command sequencer: opcodes, FSM states
// and the bit positions of fields inside the 38-bit jdo payload.
package dircc_debug_pkg;

  localparam int unsigned JDO_W = 38;

  localparam logic [2:0] OpOciRd  = 3'd0;
  localparam logic [2:0] OpOciWr  = 3'd1;
  localparam logic [2:0] OpBrkWr  = 3'd2;
  localparam logic [2:0] OpTrcCtl = 3'd3;

  localparam int unsigned OCI_ADDR_LSB = 17;
  localparam int unsigned OCI_ADDR_W   = 9;
  localparam int unsigned OCI_RD_BIT   = 34;
  localparam int unsigned OCI_DATA_LSB = 3;
  localparam int unsigned BRK_IDX_LSB  = 35;
  localparam int unsigned BRK_IDX_W    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StIssueA,
    StIssueB,
    StWait,
    StResp
  } seq_state_e;

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer and
// advances the pointer past the winner only when the grant is actually accepted.
module dircc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                accept_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [IdxW-1:0]     gnt_idx_o,
  output logic                gnt_valid_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NUM_REQ);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

  assign gnt_o = gnt_valid_o ? (NUM_REQ'(1) << gnt_idx_o) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && gnt_valid_o) begin
      ptr_d = (gnt_idx_o == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dircc_debug_cmd_sequencer.sv
// Serialises debug commands from several requesters onto the single Nios II debug
// slave command port and returns exactly one response per accepted command.
module dircc_debug_cmd_sequencer
  import dircc_debug_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_cmd,
  input  logic [9*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [JDO_W-1:0]      jdo,
  output logic                  take_action_ocimem_a,
  output logic                  take_action_ocimem_b,
  output logic                  take_action_break_a,
  output logic                  take_action_tracectrl,
  input  logic [31:0]           MonDReg,
  input  logic                  monitor_ready,
  input  logic                  monitor_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  seq_state_e      state_q, state_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [8:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic               gnt_valid;
  logic               accept;

  // Grants are only taken in IDLE and never while reset is asserted.
  assign accept = (state_q == StIdle) && gnt_valid && !reset;

  dircc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_arb (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req_valid),
    .accept_i    (accept),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign req_ready = accept ? gnt : '0;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    id_d       = id_q;
    cnt_d      = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    jdo                   = '0;
    take_action_ocimem_a  = 1'b0;
    take_action_ocimem_b  = 1'b0;
    take_action_break_a   = 1'b0;
    take_action_tracectrl = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cmd_d   = req_cmd[32'(gnt_idx) * 3 +: 3];
          addr_d  = req_addr[32'(gnt_idx) * 9 +: 9];
          data_d  = req_data[32'(gnt_idx) * 32 +: 32];
          id_d    = ID_W'(gnt_idx);
          state_d = StIssueA;
        end
      end

      StIssueA: begin
        case (cmd_q)
          OpOciRd, OpOciWr: begin
            take_action_ocimem_a             = 1'b1;
            jdo[OCI_ADDR_LSB +: OCI_ADDR_W]  = addr_q;
            jdo[OCI_RD_BIT]                  = (cmd_q == OpOciRd);
            state_d = (cmd_q == OpOciRd) ? StWait : StIssueB;
          end
          OpBrkWr: begin
            take_action_break_a            = 1'b1;
            jdo[BRK_IDX_LSB +: BRK_IDX_W]  = addr_q[2:0];
            jdo[31:0]                      = data_q;
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            state_d    = StResp;
          end
          OpTrcCtl: begin
            take_action_tracectrl = 1'b1;
            jdo[31:0]             = data_q;
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            state_d    = StResp;
          end
          default: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end
        endcase
      end

      StIssueB: begin
        take_action_ocimem_b         = 1'b1;
        jdo[OCI_DATA_LSB +: 32]      = data_q;
        state_d                      = StWait;
      end

      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (monitor_ready) begin
          // Errored transfers return zero data even for reads.
          rsp_data_d = (cmd_q == OpOciRd && !monitor_error) ? MonDReg : '0;
          rsp_err_d  = monitor_error;
          state_d    = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Response fields read as zero whenever no response is being offered.
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_data  = rsp_valid ? rsp_data_q : '0;
  assign rsp_err   = rsp_valid ? rsp_err_q : 1'b0;
  assign busy      = (state_q != StIdle);

endmodule
